// File: rtl/uart_host_pkg.sv
// Shared definitions for the UART host: FSM encodings, status bit positions and defaults.
package uart_host_pkg;

  localparam int DEFAULT_FIFO_DEPTH   = 8;
  localparam int DEFAULT_BUSY_TIMEOUT = 4;

  localparam int TX_BUSY_BIT = 0;
  localparam int RX_FULL_BIT = 1;
  localparam int RX_BUSY_BIT = 2;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_WRITE     = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_ACK   = 2'd1,
    RX_CLEAR = 2'd2
  } rx_state_t;

endpackage

// File: rtl/uart_host_byte_fifo.sv
// Byte FIFO with the head entry read straight from the storage flops and an occupancy count.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic [4:0] level,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic          push_ok, pop_ok;

  assign full    = (level_q == 5'(DEPTH));
  assign empty   = (level_q == 5'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Next pointers, storage and occupancy; overflow and underflow are masked here.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + {4'b0, push_ok} - {4'b0, pop_ok};
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/uart_host.sv
// Host-side glue between byte streams and a register-mapped UART.
//   state        | meaning
//   TX_IDLE      | wait for a queued byte, tx enable and an idle transmitter
//   TX_WRITE     | write strobe active, uart_tx_data holds the FIFO head
//   TX_WAIT_BUSY | wait for tx_busy to confirm the write; timeout retries the byte
//   TX_WAIT_DONE | byte handed over, wait for the transmitter to go idle
//   RX_IDLE      | wait for rx_full while the output slot is empty
//   RX_ACK       | read strobe active for the byte just captured
//   RX_CLEAR     | wait for rx_full to drop so the byte is not captured twice
module uart_host
  import uart_host_pkg::*;
#(
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       enable_tx,
  input  logic       enable_rx,
  output logic [7:0] uart_tx_data,
  output logic       uart_write_new_tx_data,
  output logic [7:0] uart_control_register,
  input  logic [7:0] uart_status_register,
  input  logic [7:0] uart_rx_data,
  output logic       uart_read_last_rx_data,
  output logic [4:0] tx_fifo_level,
  output logic       tx_error
);

  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  tx_state_t   tx_state_q, tx_state_d;
  rx_state_t   rx_state_q, rx_state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]  uart_tx_data_q, uart_tx_data_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic        tx_error_q, tx_error_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        rd_strobe_q, rd_strobe_d;

  logic        tx_busy, rx_full;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic        unused_status;

  assign tx_busy       = uart_status_register[TX_BUSY_BIT];
  assign rx_full       = uart_status_register[RX_FULL_BIT];
  assign unused_status = ^{uart_status_register[7:3], uart_status_register[RX_BUSY_BIT]};

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .level     (tx_fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign uart_control_register  = {6'b0, enable_rx, enable_tx};
  assign uart_tx_data           = uart_tx_data_q;
  assign uart_write_new_tx_data = wr_strobe_q;
  assign tx_error               = tx_error_q;
  assign out_data               = out_data_q;
  assign out_valid              = out_valid_q;
  assign uart_read_last_rx_data = rd_strobe_q;

  // TX sequencing: the strobe flop is set on entry to TX_WRITE so it is high for exactly that state.
  always_comb begin
    tx_state_d     = tx_state_q;
    timer_d        = timer_q;
    uart_tx_data_d = uart_tx_data_q;
    wr_strobe_d    = 1'b0;
    tx_error_d     = tx_error_q;
    fifo_pop       = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty && enable_tx && !tx_busy) begin
          tx_state_d     = TX_WRITE;
          uart_tx_data_d = fifo_head;
          wr_strobe_d    = 1'b1;
        end
      end
      TX_WRITE: begin
        tx_state_d = TX_WAIT_BUSY;
        timer_d    = TW'(BUSY_TIMEOUT - 1);
      end
      TX_WAIT_BUSY: begin
        if (tx_busy) begin
          fifo_pop   = 1'b1;
          tx_state_d = TX_WAIT_DONE;
        end else if (timer_q == '0) begin
          tx_error_d = 1'b1;
          tx_state_d = TX_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      TX_WAIT_DONE: begin
        if (!tx_busy) begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX sequencing: capture only into an empty output slot, so a held byte back-pressures the UART.
  always_comb begin
    rx_state_d  = rx_state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rd_strobe_d = 1'b0;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_full && enable_rx && !out_valid_q) begin
          rx_state_d  = RX_ACK;
          out_data_d  = uart_rx_data;
          out_valid_d = 1'b1;
          rd_strobe_d = 1'b1;
        end
      end
      RX_ACK:   rx_state_d = RX_CLEAR;
      RX_CLEAR: begin
        if (!rx_full) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tx_state_q     <= TX_IDLE;
      rx_state_q     <= RX_IDLE;
      timer_q        <= '0;
      uart_tx_data_q <= 8'h00;
      wr_strobe_q    <= 1'b0;
      tx_error_q     <= 1'b0;
      out_data_q     <= 8'h00;
      out_valid_q    <= 1'b0;
      rd_strobe_q    <= 1'b0;
    end else begin
      tx_state_q     <= tx_state_d;
      rx_state_q     <= rx_state_d;
      timer_q        <= timer_d;
      uart_tx_data_q <= uart_tx_data_d;
      wr_strobe_q    <= wr_strobe_d;
      tx_error_q     <= tx_error_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      rd_strobe_q    <= rd_strobe_d;
    end
  end

endmodule
